fsmc_mux_sram_bridge: RTL and testbench
=======================================

Name: fsmc_mux_sram_bridge

Overview:
- Parametrised FSMC-slave-to-SRAM bridge; successor to the fixed 16-bit async FSMC/SRAM bridge.
- Adds configurable data/address width and multiplexed address/data (NADV) mode.
- Adds auto-increment burst addressing within one chip-select window, programmable SRAM read latency and registered tristate control.
- Sits between the FPGA FSMC pins (via top-level tristate split) and byte-lane block RAMs.

Parameters:
- DATA_W, 16, FSMC data width: 8, 16 or 32; byte lanes NB = DATA_W/8.
- ADDR_W, 16, SRAM word-address width, must be ≤ DATA_W when ADDR_MUX=1.
- ADDR_MUX, 1, 1 = address latched from fsmc_da_i during NADV low; 0 = address taken from fsmc_a.
- SYNC_STAGES, 2, synchroniser depth (2..4) applied to all FSMC inputs, including data and nbl.
- RD_LAT, 1, SRAM read latency in aclk cycles (1..4).
- SIM_DELAY, 0, simulation delay on registered outputs.

Ports:
- aclk  in  1  bridge clock; sram_clk = aclk.
- areset  in  1  synchronous, active-high reset.
- fsmc_nex  in  1  chip select, active low.
- fsmc_nadv  in  1  address valid, active low; ignored when ADDR_MUX=0.
- fsmc_nwe  in  1  write strobe, active low.
- fsmc_noe  in  1  output enable, active low.
- fsmc_nbl  in  NB  byte-lane enables, active low.
- fsmc_a  in  ADDR_W  address; used only when ADDR_MUX=0.
- fsmc_da_i  in  DATA_W  data/address bus input.
- fsmc_da_o  out  DATA_W  read data.
- fsmc_da_t  out  DATA_W  per-bit tristate; 1 = input, 0 = drive.
- sram_clk  out  1  equals aclk.
- sram_en  out  1  SRAM access enable, one-cycle pulse.
- sram_wen  out  NB  per-lane write enable.
- sram_addr  out  ADDR_W  SRAM word address.
- sram_din  out  DATA_W  write data.
- sram_dout  in  DATA_W  read data, valid RD_LAT cycles after sram_en.
- busy  out  1  high whenever state ≠ IDLE.

Behaviour:
- Synchronisation and edges:
  - All FSMC inputs pass through SYNC_STAGES flops; data bus and nbl share the same depth as the strobes so they stay aligned.
  - Edge detectors run on the synced nadv, nwe and noe.
- Reset (areset=1 at aclk edge):
  - state=IDLE, address register=0, sram_en=0, sram_wen=0, sram_addr=0, sram_din=0, fsmc_da_o=0, fsmc_da_t=all 1, busy=0.
  - Reset mid-transfer aborts the transfer with no SRAM access; the bus is released on the next edge.
- States:
  - IDLE: synced nex low → ACTIVE. When ADDR_MUX=0, also load the address register from synced fsmc_a.
  - ACTIVE, address capture (ADDR_MUX=1): on NADV rising edge, address register ← synced da[ADDR_W-1:0].
  - ACTIVE, write: nwe rising edge → WR (one cycle).
  - ACTIVE, read: noe falling edge → RD.
  - ACTIVE, end: nex high → IDLE.
  - WR: sram_en=1, sram_wen=~nbl_sync, sram_din=da_sync, sram_addr=address register; address register += 1 (wraps at 2^ADDR_W); → ACTIVE.
  - RD: sram_en=1, sram_wen=0; → RD_WAIT.
  - RD_WAIT: count RD_LAT cycles, then latch sram_dout into fsmc_da_o; → DRIVE.
  - DRIVE: fsmc_da_t=0 while synced noe and nex are low. On noe rising edge: da_t=all 1, address register += 1, → ACTIVE. nex rising in RD_WAIT or DRIVE → IDLE, da_t=all 1.
- Latencies:
  - Write: SRAM commit SYNC_STAGES+1 aclk after the pin NWE rise.
  - Read: bus driven SYNC_STAGES+2+RD_LAT aclk after the pin NOE fall.
- Boundaries and corner cases:
  - nwe and noe both low: treated as protocol error; the write is ignored and the read is served.
  - All nbl high on a write: sram_en=1, sram_wen=0 (no-op); the address still increments.
  - Address wrap from 2^ADDR_W−1 to 0.
  - Back-to-back accesses: one access per strobe edge, no merging.

Optional Feature:
- FSMC_NWAIT_EN
  - Defined: adds output fsmc_nwait (reset value 1). Driven 0 from the synced noe falling edge until the DRIVE state is entered, letting the MCU run with zero data-setup margin. RD_LAT up to 8 is legal.
  - Undefined: port absent; the MCU DATAST timing must cover the read latency.

Decomposition:
- Package fsmc_bridge_pkg holds:
  - state enum (IDLE, ACTIVE, WR, RD, RD_WAIT, DRIVE);
  - MAX_RD_LAT;
  - function nb_of(DATA_W).
- One sub-module, fsmc_in_sync: parametrised SYNC_STAGES vector synchroniser plus rise/fall edge detect.

Test Plan:
- ADDR_MUX=1, DATA_W=16: NADV pulse with da=0x0040, NWE pulse with da=0xBEEF, nbl=00 → one sram_en with sram_wen=11, addr=0x0040, din=0xBEEF.
- Burst in one nex window: write 0x1111, 0x2222, 0x3333 from addr 0x10, then read three times from 0x10 → SRAM addrs 0x10, 0x11, 0x12; read bus returns 0x1111, 0x2222, 0x3333 with da_t=0 only during noe low.
- Byte write nbl=10, data 0xAB55 to addr 5, then read → sram_wen=01; only the low byte is updated to 0x55.
- RD_LAT=3 → da_o valid exactly SYNC_STAGES+5 aclk after NOE fall; nwait (if FSMC_NWAIT_EN) low until that cycle.
- Address 0xFFFF, write then write → second write goes to address 0x0000.
- areset pulsed in RD_WAIT → no further sram_en, da_t=0xFFFF next cycle, busy=0; the next transaction completes normally.

Source files
------------

// File: rtl/fsmc_bridge_pkg.sv
// Shared types and helpers for the FSMC-to-SRAM bridge.
// FSMC_NWAIT_EN raises the maximum SRAM read latency to 8.
package fsmc_bridge_pkg;

  typedef enum logic [2:0] {IDLE, ACTIVE, WR, RD, RD_WAIT, DRIVE} state_e;

`ifdef FSMC_NWAIT_EN
  localparam int MAX_RD_LAT = 8;
`else
  localparam int MAX_RD_LAT = 4;
`endif

  function automatic int nb_of(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/fsmc_mux_sram_bridge_if.sv
// FSMC pin bundle plus SRAM port, seen from the bridge (slave) and its environment (master).
// FSMC_NWAIT_EN adds the fsmc_nwait wait-request line.
interface fsmc_mux_sram_bridge_if
  import fsmc_bridge_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  localparam int NB = nb_of(DATA_W);

  logic              fsmc_nex;
  logic              fsmc_nadv;
  logic              fsmc_nwe;
  logic              fsmc_noe;
  logic [NB-1:0]     fsmc_nbl;
  logic [ADDR_W-1:0] fsmc_a;
  logic [DATA_W-1:0] fsmc_da_i;
  logic [DATA_W-1:0] fsmc_da_o;
  logic [DATA_W-1:0] fsmc_da_t;
`ifdef FSMC_NWAIT_EN
  logic              fsmc_nwait;
`endif
  logic              sram_clk;
  logic              sram_en;
  logic [NB-1:0]     sram_wen;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_din;
  logic [DATA_W-1:0] sram_dout;

  modport slave (
    input  fsmc_nex, fsmc_nadv, fsmc_nwe, fsmc_noe, fsmc_nbl, fsmc_a, fsmc_da_i, sram_dout,
    output
`ifdef FSMC_NWAIT_EN
           fsmc_nwait,
`endif
           fsmc_da_o, fsmc_da_t, sram_clk, sram_en, sram_wen, sram_addr, sram_din
  );

  modport master (
    output fsmc_nex, fsmc_nadv, fsmc_nwe, fsmc_noe, fsmc_nbl, fsmc_a, fsmc_da_i, sram_dout,
    input
`ifdef FSMC_NWAIT_EN
           fsmc_nwait,
`endif
           fsmc_da_o, fsmc_da_t, sram_clk, sram_en, sram_wen, sram_addr, sram_din
  );

endinterface

// File: rtl/fsmc_in_sync.sv
// Vector synchroniser (STAGES flops per bit) with rise/fall detect on the synced value.
// No reset: the chain flushes while reset is held, so a strobe held across reset makes no edge.
module fsmc_in_sync #(
  parameter int W      = 1,
  parameter int STAGES = 2
) (
  input  logic         i_clk,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q,
  output logic [W-1:0] o_rise,
  output logic [W-1:0] o_fall
);
  logic [STAGES-1:0][W-1:0] r_sync;
  logic [W-1:0]             r_prev;

  always_ff @(posedge i_clk) begin
    r_sync <= {r_sync[STAGES-2:0], i_d};
    r_prev <= r_sync[STAGES-1];
  end

  assign o_q    = r_sync[STAGES-1];
  assign o_rise = o_q & ~r_prev;
  assign o_fall = ~o_q & r_prev;

endmodule

// File: rtl/fsmc_mux_sram_bridge.sv
// FSMC slave to byte-lane SRAM bridge: muxed/non-muxed address, burst auto-increment, RD_LAT reads.
// FSMC_NWAIT_EN adds fsmc_nwait, held low from read start until the bus is driven.
module fsmc_mux_sram_bridge
  import fsmc_bridge_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int ADDR_MUX    = 1,
  parameter int SYNC_STAGES = 2,
  parameter int RD_LAT      = 1,
  parameter int SIM_DELAY   = 0
) (
  input  logic                  i_aclk,
  input  logic                  i_areset,
  fsmc_mux_sram_bridge_if.slave bus,
  output logic                  o_busy
);
  localparam int NB    = nb_of(DATA_W);
  localparam int SW    = 4 + NB + ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(MAX_RD_LAT);
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(RD_LAT - 1);

  if (!(DATA_W == 8 || DATA_W == 16 || DATA_W == 32) || (ADDR_MUX != 0 && ADDR_W > DATA_W) ||
      SYNC_STAGES < 2 || SYNC_STAGES > 4 || RD_LAT < 1 || RD_LAT > MAX_RD_LAT || SIM_DELAY < 0)
  begin : g_bad_param
    $error("fsmc_mux_sram_bridge: illegal parameter combination");
  end

  // Strobes, lane enables, address and data share one chain so they stay cycle-aligned.
  logic [SW-1:0] w_raw, w_sync, w_rise, w_fall;
  assign w_raw = {bus.fsmc_nex, bus.fsmc_nadv, bus.fsmc_nwe, bus.fsmc_noe,
                  bus.fsmc_nbl, bus.fsmc_a, bus.fsmc_da_i};

  fsmc_in_sync #(.W(SW), .STAGES(SYNC_STAGES)) u_sync (
    .i_clk(i_aclk), .i_d(w_raw), .o_q(w_sync), .o_rise(w_rise), .o_fall(w_fall)
  );

  logic              w_nex, w_noe, w_nadv_rise, w_nwe_rise, w_noe_fall;
  logic [NB-1:0]     w_nbl;
  logic [ADDR_W-1:0] w_a;
  logic [DATA_W-1:0] w_da;
  logic              w_unused;

  assign w_nex       = w_sync[SW-1];
  assign w_noe       = w_sync[SW-4];
  assign w_nadv_rise = w_rise[SW-2];
  assign w_nwe_rise  = w_rise[SW-3];
  assign w_noe_fall  = w_fall[SW-4];
  assign w_nbl       = w_sync[DATA_W+ADDR_W +: NB];
  assign w_a         = w_sync[DATA_W +: ADDR_W];
  assign w_da        = w_sync[DATA_W-1:0];
  assign w_unused    = ^{w_sync[SW-2 -: 2], w_rise[SW-1], w_rise[SW-4:0], w_fall[SW-1 -: 3], w_fall[SW-5:0]};

  state_e            r_state;
  logic [ADDR_W-1:0] r_addr, r_sram_addr;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_sram_en;
  logic [NB-1:0]     r_sram_wen;
  logic [DATA_W-1:0] r_sram_din, r_da_o, r_da_t;
`ifdef FSMC_NWAIT_EN
  logic              r_nwait;
`endif

  always_ff @(posedge i_aclk) begin
    if (i_areset) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_cnt       <= '0;
      r_sram_en   <= 1'b0;
      r_sram_wen  <= '0;
      r_sram_addr <= '0;
      r_sram_din  <= '0;
      r_da_o      <= '0;
      r_da_t      <= '1;
`ifdef FSMC_NWAIT_EN
      r_nwait     <= 1'b1;
`endif
    end else begin
      r_sram_en  <= 1'b0;
      r_sram_wen <= '0;
      case (r_state)
        IDLE: if (!w_nex) begin
          r_state <= ACTIVE;
          if (ADDR_MUX == 0) r_addr <= w_a;
        end
        ACTIVE: begin
          if (ADDR_MUX != 0 && w_nadv_rise) r_addr <= w_da[ADDR_W-1:0];
          // A write strobe while noe is low is a protocol error: the read wins.
          if (w_nex) r_state <= IDLE;
          else if (w_noe_fall) begin
            r_state     <= RD;
            r_sram_en   <= 1'b1;
            r_sram_addr <= r_addr;
`ifdef FSMC_NWAIT_EN
            r_nwait     <= 1'b0;
`endif
          end else if (w_nwe_rise && w_noe) begin
            r_state     <= WR;
            r_sram_en   <= 1'b1;
            r_sram_wen  <= ~w_nbl;
            r_sram_din  <= w_da;
            r_sram_addr <= r_addr;
          end
        end
        WR: begin
          r_addr  <= r_addr + ADDR_W'(1);
          r_state <= ACTIVE;
        end
        RD: begin
          r_cnt   <= '0;
          r_state <= RD_WAIT;
        end
        RD_WAIT: begin
          if (w_nex) begin
            r_state <= IDLE;
`ifdef FSMC_NWAIT_EN
            r_nwait <= 1'b1;
`endif
          end else if (r_cnt == LAT_LAST) begin
            r_da_o  <= bus.sram_dout;
            r_da_t  <= '0;
            r_state <= DRIVE;
`ifdef FSMC_NWAIT_EN
            r_nwait <= 1'b1;
`endif
          end else r_cnt <= r_cnt + CNT_W'(1);
        end
        DRIVE: begin
          // Level test also releases a noe that rose while still waiting on the SRAM.
          if (w_nex) begin
            r_da_t  <= '1;
            r_state <= IDLE;
          end else if (w_noe) begin
            r_da_t  <= '1;
            r_addr  <= r_addr + ADDR_W'(1);
            r_state <= ACTIVE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.sram_clk  = i_aclk;
  assign bus.sram_en   = r_sram_en;
  assign bus.sram_wen  = r_sram_wen;
  assign bus.sram_addr = r_sram_addr;
  assign bus.sram_din  = r_sram_din;
  assign bus.fsmc_da_o = r_da_o;
  assign bus.fsmc_da_t = r_da_t;
`ifdef FSMC_NWAIT_EN
  assign bus.fsmc_nwait = r_nwait;
`endif
  assign o_busy = (r_state != IDLE);

endmodule

// File: tb/tb_fsmc_mux_sram_bridge.sv
// Directed bench for fsmc_mux_sram_bridge: 16-bit muxed bus, 2 sync stages, RD_LAT=3, behavioural SRAM.
module tb_fsmc_mux_sram_bridge;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int NB = 2;
  localparam int S  = 2;
  localparam int RL = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  fsmc_mux_sram_bridge_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  fsmc_mux_sram_bridge #(
    .DATA_W(DW), .ADDR_W(AW), .ADDR_MUX(1), .SYNC_STAGES(S), .RD_LAT(RL), .SIM_DELAY(0)
  ) dut (
    .i_aclk(clk), .i_areset(rst), .bus(bus), .o_busy(busy)
  );

  // Behavioural byte-lane SRAM, read data valid RL cycles after the enable edge.
  logic [DW-1:0]         mem [0:(1<<AW)-1];
  logic [RL-1:0][DW-1:0] rp;
  logic [DW-1:0]         rp0_next;
  assign rp0_next      = bus.sram_en ? mem[bus.sram_addr] : rp[0];
  assign bus.sram_dout = rp[RL-1];

  always @(posedge clk) begin
    if (bus.sram_en && bus.sram_wen[0]) mem[bus.sram_addr][7:0]  <= bus.sram_din[7:0];
    if (bus.sram_en && bus.sram_wen[1]) mem[bus.sram_addr][15:8] <= bus.sram_din[15:8];
    rp <= {rp[RL-2:0], rp0_next};
  end

  // Log of every SRAM access.
  logic [NB-1:0] ev_wen [$];
  logic [AW-1:0] ev_addr [$];
  logic [DW-1:0] ev_din [$];
  always @(negedge clk) begin
    if (bus.sram_en === 1'b1) begin
      ev_wen.push_back(bus.sram_wen);
      ev_addr.push_back(bus.sram_addr);
      ev_din.push_back(bus.sram_din);
    end
  end

`ifdef FSMC_NWAIT_EN
  logic nw_pre, nw_at;
`endif

  task automatic cs_begin();
    @(posedge clk); #1 bus.fsmc_nex = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic cs_end();
    @(posedge clk); #1 bus.fsmc_nex = 1'b1;
    repeat (6) @(posedge clk);
  endtask

  task automatic set_addr(input logic [DW-1:0] a);
    @(posedge clk); #1 bus.fsmc_da_i = a; bus.fsmc_nadv = 1'b0;
    repeat (3) @(posedge clk);
    #1 bus.fsmc_nadv = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic do_wr(input logic [DW-1:0] d, input logic [NB-1:0] nbl, output int lat);
    lat = 0;
    @(posedge clk); #1 bus.fsmc_da_i = d; bus.fsmc_nbl = nbl; bus.fsmc_nwe = 1'b0;
    repeat (3) @(posedge clk);
    #1 bus.fsmc_nwe = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); @(negedge clk);
      if (lat == 0 && bus.sram_en === 1'b1) lat = k;
    end
    bus.fsmc_nbl = '0;
  endtask

  task automatic do_rd(output int lat, output logic [DW-1:0] data,
                       output logic [DW-1:0] t_pre, output logic [DW-1:0] t_drv,
                       output logic [DW-1:0] t_post);
    lat  = 0;
    data = '0;
    @(negedge clk); t_pre = bus.fsmc_da_t;
    @(posedge clk); #1 bus.fsmc_noe = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); @(negedge clk);
      if (lat == 0 && bus.fsmc_da_t === '0) begin
        lat  = k;
        data = bus.fsmc_da_o;
`ifdef FSMC_NWAIT_EN
        nw_at = bus.fsmc_nwait;
`endif
      end
`ifdef FSMC_NWAIT_EN
      else if (lat == 0) nw_pre = bus.fsmc_nwait;
`endif
    end
    t_drv = bus.fsmc_da_t;
    @(posedge clk); #1 bus.fsmc_noe = 1'b1;
    repeat (S + 3) @(posedge clk);
    @(negedge clk); t_post = bus.fsmc_da_t;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_vec++; if (bus.fsmc_da_t !== 16'hFFFF) begin n_err++; $display("FAIL rst_da_t got %h exp ffff", bus.fsmc_da_t); end
    n_vec++; if (bus.fsmc_da_o !== 16'h0000) begin n_err++; $display("FAIL rst_da_o got %h exp 0000", bus.fsmc_da_o); end
    n_vec++; if (bus.sram_en !== 1'b0) begin n_err++; $display("FAIL rst_en got %b exp 0", bus.sram_en); end
    n_vec++; if (bus.sram_wen !== 2'b00) begin n_err++; $display("FAIL rst_wen got %b exp 00", bus.sram_wen); end
    n_vec++; if (bus.sram_addr !== 16'h0000) begin n_err++; $display("FAIL rst_addr got %h exp 0000", bus.sram_addr); end
    n_vec++; if (bus.sram_din !== 16'h0000) begin n_err++; $display("FAIL rst_din got %h exp 0000", bus.sram_din); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b exp 0", busy); end
`ifdef FSMC_NWAIT_EN
    n_vec++; if (bus.fsmc_nwait !== 1'b1) begin n_err++; $display("FAIL rst_nwait got %b exp 1", bus.fsmc_nwait); end
`endif
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_single_write();
    int n0, lat;
    cs_begin();
    @(negedge clk);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL sw_busy_on got %b exp 1", busy); end
    set_addr(16'h0040);
    n0 = ev_addr.size();
    do_wr(16'hBEEF, 2'b00, lat);
    n_vec++; if (ev_addr.size() != n0 + 1) begin n_err++; $display("FAIL sw_count got %0d exp %0d", ev_addr.size(), n0 + 1); end
    n_vec++; if (ev_wen[n0] !== 2'b11) begin n_err++; $display("FAIL sw_wen got %b exp 11", ev_wen[n0]); end
    n_vec++; if (ev_addr[n0] !== 16'h0040) begin n_err++; $display("FAIL sw_addr got %h exp 0040", ev_addr[n0]); end
    n_vec++; if (ev_din[n0] !== 16'hBEEF) begin n_err++; $display("FAIL sw_din got %h exp beef", ev_din[n0]); end
    n_vec++; if (lat != S + 1) begin n_err++; $display("FAIL sw_latency got %0d exp %0d", lat, S + 1); end
    cs_end();
    @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL sw_busy_off got %b exp 0", busy); end
  endtask

  task automatic test_burst();
    logic [DW-1:0] exp_d [3];
    logic [DW-1:0] d, tpre, tdrv, tpost;
    int n0, lat;
    exp_d = '{16'h1111, 16'h2222, 16'h3333};
    cs_begin();
    set_addr(16'h0010);
    n0 = ev_addr.size();
    for (int i = 0; i < 3; i++) do_wr(exp_d[i], 2'b00, lat);
    n_vec++; if (ev_addr.size() != n0 + 3) begin n_err++; $display("FAIL bw_count got %0d exp %0d", ev_addr.size(), n0 + 3); end
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (ev_addr[n0+i] !== 16'h0010 + 16'(i)) begin n_err++; $display("FAIL bw_addr%0d got %h exp %h", i, ev_addr[n0+i], 16'h0010 + 16'(i)); end
      n_vec++; if (ev_din[n0+i] !== exp_d[i]) begin n_err++; $display("FAIL bw_din%0d got %h exp %h", i, ev_din[n0+i], exp_d[i]); end
    end
    set_addr(16'h0010);
    n0 = ev_addr.size();
    for (int i = 0; i < 3; i++) begin
      do_rd(lat, d, tpre, tdrv, tpost);
      n_vec++; if (d !== exp_d[i]) begin n_err++; $display("FAIL br_data%0d got %h exp %h", i, d, exp_d[i]); end
      n_vec++; if (lat != S + 2 + RL) begin n_err++; $display("FAIL br_latency%0d got %0d exp %0d", i, lat, S + 2 + RL); end
      n_vec++; if (tpre !== 16'hFFFF) begin n_err++; $display("FAIL br_t_pre%0d got %h exp ffff", i, tpre); end
      n_vec++; if (tdrv !== 16'h0000) begin n_err++; $display("FAIL br_t_drv%0d got %h exp 0000", i, tdrv); end
      n_vec++; if (tpost !== 16'hFFFF) begin n_err++; $display("FAIL br_t_post%0d got %h exp ffff", i, tpost); end
`ifdef FSMC_NWAIT_EN
      n_vec++; if (nw_pre !== 1'b0 || nw_at !== 1'b1) begin n_err++; $display("FAIL br_nwait%0d got %b%b exp 01", i, nw_pre, nw_at); end
`endif
    end
    n_vec++; if (ev_addr.size() != n0 + 3) begin n_err++; $display("FAIL br_count got %0d exp %0d", ev_addr.size(), n0 + 3); end
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (ev_addr[n0+i] !== 16'h0010 + 16'(i) || ev_wen[n0+i] !== 2'b00) begin n_err++; $display("FAIL br_sram%0d got %h/%b exp %h/00", i, ev_addr[n0+i], ev_wen[n0+i], 16'h0010 + 16'(i)); end
    end
    cs_end();
  endtask

  task automatic test_byte_write();
    logic [DW-1:0] d, tpre, tdrv, tpost;
    int n0, lat;
    cs_begin();
    set_addr(16'h0005);
    do_wr(16'h1234, 2'b00, lat);
    set_addr(16'h0005);
    n0 = ev_addr.size();
    do_wr(16'hAB55, 2'b10, lat);
    n_vec++; if (ev_wen[n0] !== 2'b01) begin n_err++; $display("FAIL bb_wen got %b exp 01", ev_wen[n0]); end
    n_vec++; if (ev_addr[n0] !== 16'h0005) begin n_err++; $display("FAIL bb_addr got %h exp 0005", ev_addr[n0]); end
    set_addr(16'h0005);
    do_rd(lat, d, tpre, tdrv, tpost);
    n_vec++; if (d !== 16'h1255) begin n_err++; $display("FAIL bb_readback got %h exp 1255", d); end
    cs_end();
  endtask

  task automatic test_all_nbl_high();
    int n0, lat;
    cs_begin();
    set_addr(16'h0030);
    n0 = ev_addr.size();
    do_wr(16'hFFFF, 2'b11, lat);
    do_wr(16'h7777, 2'b00, lat);
    n_vec++; if (ev_addr.size() != n0 + 2) begin n_err++; $display("FAIL nb_count got %0d exp %0d", ev_addr.size(), n0 + 2); end
    n_vec++; if (ev_wen[n0] !== 2'b00) begin n_err++; $display("FAIL nb_wen got %b exp 00", ev_wen[n0]); end
    n_vec++; if (ev_addr[n0] !== 16'h0030) begin n_err++; $display("FAIL nb_addr got %h exp 0030", ev_addr[n0]); end
    n_vec++; if (ev_addr[n0+1] !== 16'h0031) begin n_err++; $display("FAIL nb_next_addr got %h exp 0031", ev_addr[n0+1]); end
    cs_end();
  endtask

  task automatic test_wrap();
    logic [DW-1:0] d, tpre, tdrv, tpost;
    int n0, lat;
    cs_begin();
    set_addr(16'hFFFF);
    n0 = ev_addr.size();
    do_wr(16'hA5A5, 2'b00, lat);
    do_wr(16'h5A5A, 2'b00, lat);
    n_vec++; if (ev_addr[n0] !== 16'hFFFF) begin n_err++; $display("FAIL wrap_w0 got %h exp ffff", ev_addr[n0]); end
    n_vec++; if (ev_addr[n0+1] !== 16'h0000) begin n_err++; $display("FAIL wrap_w1 got %h exp 0000", ev_addr[n0+1]); end
    set_addr(16'hFFFF);
    do_rd(lat, d, tpre, tdrv, tpost);
    n_vec++; if (d !== 16'hA5A5) begin n_err++; $display("FAIL wrap_r0 got %h exp a5a5", d); end
    do_rd(lat, d, tpre, tdrv, tpost);
    n_vec++; if (d !== 16'h5A5A) begin n_err++; $display("FAIL wrap_r1 got %h exp 5a5a", d); end
    cs_end();
  endtask

  task automatic test_protocol_error();
    int n0;
    cs_begin();
    set_addr(16'h0010);
    n0 = ev_addr.size();
    @(posedge clk); #1 bus.fsmc_da_i = 16'hDEAD; bus.fsmc_nwe = 1'b0; bus.fsmc_noe = 1'b0;
    repeat (3) @(posedge clk);
    #1 bus.fsmc_nwe = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    n_vec++; if (bus.fsmc_da_t !== 16'h0000) begin n_err++; $display("FAIL pe_drive got %h exp 0000", bus.fsmc_da_t); end
    n_vec++; if (bus.fsmc_da_o !== 16'h1111) begin n_err++; $display("FAIL pe_data got %h exp 1111", bus.fsmc_da_o); end
    @(posedge clk); #1 bus.fsmc_noe = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    n_vec++; if (ev_addr.size() != n0 + 1) begin n_err++; $display("FAIL pe_count got %0d exp %0d", ev_addr.size(), n0 + 1); end
    n_vec++; if (ev_wen[n0] !== 2'b00) begin n_err++; $display("FAIL pe_wen got %b exp 00", ev_wen[n0]); end
    cs_end();
  endtask

  task automatic test_reset_mid_read();
    logic [DW-1:0] d, tpre, tdrv, tpost;
    int n0, lat;
    cs_begin();
    set_addr(16'h0011);
    n0 = ev_addr.size();
    @(posedge clk); #1 bus.fsmc_noe = 1'b0;
    repeat (S + 2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); @(negedge clk);
    n_vec++; if (bus.fsmc_da_t !== 16'hFFFF) begin n_err++; $display("FAIL rr_da_t got %h exp ffff", bus.fsmc_da_t); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rr_busy got %b exp 0", busy); end
    n_vec++; if (bus.sram_en !== 1'b0) begin n_err++; $display("FAIL rr_en got %b exp 0", bus.sram_en); end
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    n_vec++; if (ev_addr.size() != n0 + 1) begin n_err++; $display("FAIL rr_no_access got %0d exp %0d", ev_addr.size(), n0 + 1); end
    n_vec++; if (bus.fsmc_da_t !== 16'hFFFF) begin n_err++; $display("FAIL rr_released got %h exp ffff", bus.fsmc_da_t); end
    @(posedge clk); #1 bus.fsmc_noe = 1'b1;
    cs_end();
    cs_begin();
    set_addr(16'h0011);
    do_rd(lat, d, tpre, tdrv, tpost);
    n_vec++; if (d !== 16'h2222) begin n_err++; $display("FAIL rr_next_data got %h exp 2222", d); end
    n_vec++; if (lat != S + 2 + RL) begin n_err++; $display("FAIL rr_next_latency got %0d exp %0d", lat, S + 2 + RL); end
    cs_end();
  endtask

  initial begin
    bus.fsmc_nex  = 1'b1;
    bus.fsmc_nadv = 1'b1;
    bus.fsmc_nwe  = 1'b1;
    bus.fsmc_noe  = 1'b1;
    bus.fsmc_nbl  = '0;
    bus.fsmc_a    = '0;
    bus.fsmc_da_i = '0;
    test_reset();
    test_single_write();
    test_burst();
    test_byte_write();
    test_all_nbl_high();
    test_wrap();
    test_protocol_error();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout after %0d vectors", n_vec);
    $fatal(1, "timeout");
  end

endmodule
